// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// The parity feature is enabled by the UART_TX_PARITY_EN macro in uart_tx_buf.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10,
      PAR_RSVD = 2'b11
   } parity_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam logic [2:0] DBITS_5 = 3'd0;
   localparam logic [2:0] DBITS_6 = 3'd1;
   localparam logic [2:0] DBITS_7 = 3'd2;
   localparam logic [2:0] DBITS_8 = 3'd3;
   localparam logic [2:0] DBITS_9 = 3'd4;

   // Index of the last data bit in a frame; codes above DBITS_9 behave as 9 bits.
   function automatic logic [3:0] last_data_idx(input logic [2:0] code);
      if (code > DBITS_9) begin
         return 4'd8;
      end
      return {1'b0, code} + 4'd4;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read port; rd_data updates only on an accepted pop.
// Pointers wrap naturally, so Depth must be a power of two.
module sync_fifo #(
   parameter int Width = 9,
   parameter int Depth = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [Width-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [Width-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(Depth):0] level
);

   localparam int AddrWidth = $clog2(Depth);

   logic [Width-1:0]     mem_q [Depth];
   logic [AddrWidth-1:0] wr_ptr_q;
   logic [AddrWidth-1:0] rd_ptr_q;
   logic [AddrWidth:0]   count_q;
   logic [AddrWidth:0]   count_d;
   logic [Width-1:0]     rd_data_q;
   logic                 wr_fire;
   logic                 rd_fire;

   assign full    = (count_q == (AddrWidth+1)'(Depth));
   assign empty   = (count_q == '0);
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;
   assign level   = count_q;
   assign rd_data = rd_data_q;

   always_comb begin
      count_d = count_q;
      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage carries no reset so it maps onto block RAM; the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         count_q <= count_d;
         if (wr_fire) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_fire) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_data_q <= mem_q[rd_ptr_q];
         end
      end
   end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO feeding a frame serializer with runtime-configurable framing.
// Define UART_TX_PARITY_EN to build the optional parity bit; otherwise parity_mode is ignored.
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int ClkDivWidth = 16,
   parameter int FifoDepth   = 4,
   parameter int MaxDataBits = 9
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ClkDivWidth-1:0]     clk_div,
   input  logic [2:0]                 data_bits,
   input  logic [1:0]                 parity_mode,
   input  logic                       two_stop,
   input  logic                       tx_enable,
   input  logic [MaxDataBits-1:0]     data_in,
   input  logic                       data_in_valid,
   output logic                       data_in_ready,
   output logic                       out_bit,
   output logic                       busy,
   output logic [$clog2(FifoDepth):0] fifo_level
);

   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic [MaxDataBits-1:0] fifo_rd_data;

   tx_state_t              state_q;
   logic [ClkDivWidth-1:0] div_q;
   logic [ClkDivWidth-1:0] div_cnt_q;
   logic [2:0]             dbits_q;
   logic                   two_stop_q;
   logic [3:0]             bit_cnt_q;
   logic [MaxDataBits-1:0] shift_q;
   logic                   out_bit_q;
   logic                   busy_q;

   logic                   bit_end;
   logic                   start_ok;
   logic                   stop_done;
   logic [3:0]             last_idx;

   sync_fifo #(
      .Width (MaxDataBits),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (data_in_valid),
      .wr_data (data_in),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign data_in_ready = !fifo_full;
   assign out_bit       = out_bit_q;
   assign busy          = busy_q;

   assign bit_end   = (div_cnt_q == div_q);
   assign start_ok  = tx_enable && !fifo_empty;
   assign last_idx  = last_data_idx(dbits_q);
   // With two stop bits, bit_cnt_q[0] marks the second stop period.
   assign stop_done = (state_q == ST_STOP) && bit_end && (!two_stop_q || bit_cnt_q[0]);
   assign fifo_pop  = start_ok && ((state_q == ST_IDLE) || stop_done);

`ifdef UART_TX_PARITY_EN
   parity_mode_t           par_q;
   logic                   parity_bit_q;
   logic                   parity_on;
   logic [MaxDataBits-1:0] data_mask;
   logic                   word_parity;

   for (genvar gi = 0; gi < MaxDataBits; gi++) begin : g_mask
      assign data_mask[gi] = (gi <= int'(last_idx));
   end

   assign word_parity = ^(fifo_rd_data & data_mask);
   assign parity_on   = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
`else
   logic unused_parity;
   assign unused_parity = ^parity_mode;
`endif

   // Frame configuration is captured together with each pop and held for that frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q      <= '0;
         dbits_q    <= DBITS_5;
         two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= PAR_NONE;
`endif
      end else if (fifo_pop) begin
         div_q      <= clk_div;
         dbits_q    <= data_bits;
         two_stop_q <= two_stop;
`ifdef UART_TX_PARITY_EN
         par_q      <= parity_mode_t'(parity_mode);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         out_bit_q <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit_q <= 1'b0;
`endif
      end else begin
         if (state_q != ST_IDLE) begin
            div_cnt_q <= bit_end ? '0 : div_cnt_q + 1'b1;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (fifo_pop) begin
                  state_q   <= ST_START;
                  out_bit_q <= 1'b0;
                  busy_q    <= 1'b1;
                  div_cnt_q <= '0;
                  bit_cnt_q <= '0;
               end
            end

            // The popped word is stable in fifo_rd_data for the whole start bit.
            ST_START: begin
               if (bit_end) begin
                  state_q   <= ST_DATA;
                  out_bit_q <= fifo_rd_data[0];
                  shift_q   <= fifo_rd_data >> 1;
                  bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                  parity_bit_q <= word_parity ^ (par_q == PAR_ODD);
`endif
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  if (bit_cnt_q == last_idx) begin
                     bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                     if (parity_on) begin
                        state_q   <= ST_PARITY;
                        out_bit_q <= parity_bit_q;
                     end else begin
                        state_q   <= ST_STOP;
                        out_bit_q <= 1'b1;
                     end
`else
                     state_q   <= ST_STOP;
                     out_bit_q <= 1'b1;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     out_bit_q <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  state_q   <= ST_STOP;
                  out_bit_q <= 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (bit_end) begin
                  if (!stop_done) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end else if (fifo_pop) begin
                     state_q   <= ST_START;
                     out_bit_q <= 1'b0;
                     bit_cnt_q <= '0;
                  end else begin
                     state_q   <= ST_IDLE;
                     busy_q    <= 1'b0;
                     bit_cnt_q <= '0;
                  end
               end
            end

            default: begin
               state_q   <= ST_IDLE;
               out_bit_q <= 1'b1;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: writes push expected line waveforms, a monitor checks them.
// Honours UART_TX_PARITY_EN so the reference frames match the build under test.
module tb_uart_tx_buf;

   localparam int ClkDivWidth = 16;
   localparam int FifoDepth   = 4;
   localparam int MaxDataBits = 9;
`ifdef UART_TX_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [ClkDivWidth-1:0] clk_div = '0;
   logic [2:0]             data_bits = 3'd3;
   logic [1:0]             parity_mode = 2'b00;
   logic                   two_stop = 1'b0;
   logic                   tx_enable = 1'b0;
   logic [MaxDataBits-1:0] data_in = '0;
   logic                   data_in_valid = 1'b0;
   logic                   data_in_ready;
   logic                   out_bit;
   logic                   busy;
   logic [$clog2(FifoDepth):0] fifo_level;

   uart_tx_buf #(
      .ClkDivWidth (ClkDivWidth),
      .FifoDepth   (FifoDepth),
      .MaxDataBits (MaxDataBits)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .clk_div       (clk_div),
      .data_bits     (data_bits),
      .parity_mode   (parity_mode),
      .two_stop      (two_stop),
      .tx_enable     (tx_enable),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .out_bit       (out_bit),
      .busy          (busy),
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          period;
      logic [8:0]  word;
   } frame_t;

   frame_t exp_q[$];
   int     gaps_q[$];
   int     compared   = 0;
   int     mismatched = 0;
   int     frame_no   = 0;
   bit     mon_busy   = 1'b0;

   // Line-level frame implied by a word and the current configuration inputs.
   function automatic frame_t build_frame(input logic [8:0] w);
      frame_t f;
      int     nb;
      int     n;
      logic   p;
      f.bits = '0;
      n  = 0;
      p  = 1'b0;
      nb = (data_bits > 3'd4) ? 9 : int'(data_bits) + 5;
      f.bits[n] = 1'b0;
      n++;
      for (int i = 0; i < nb; i++) begin
         f.bits[n] = w[i];
         p ^= w[i];
         n++;
      end
      if (ParEn && (parity_mode == 2'b01 || parity_mode == 2'b10)) begin
         f.bits[n] = (parity_mode == 2'b10) ? ~p : p;
         n++;
      end
      f.bits[n] = 1'b1;
      n++;
      if (two_stop) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.nbits  = n;
      f.period = int'(clk_div) + 1;
      f.word   = w;
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      compared++;
      if (actual !== required) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, actual, required);
      end else begin
         $display("check %s: %0d ok", name, actual);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the write edge.
   task automatic write_word(input logic [8:0] w, input bit accepted);
      if (accepted) exp_q.push_back(build_frame(w));
      data_in       = w;
      data_in_valid = 1'b1;
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: %0d frames pending after %0d cycles, required 0",
                  exp_q.size() + int'(mon_busy), budget);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int div, input int db, input int pm, input bit ts);
      clk_div     = ClkDivWidth'(div);
      data_bits   = 3'(db);
      parity_mode = 2'(pm);
      two_stop    = ts;
   endtask

   // Monitor: waits for a start bit, then checks every line cycle of the expected frame.
   initial begin
      frame_t cur;
      int     mon_idx;
      int     mon_err;
      int     idle_run;
      bit     spurious;
      mon_idx  = 0;
      mon_err  = 0;
      idle_run = 0;
      spurious = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_busy = 1'b0;
            exp_q.delete();
            idle_run = 0;
            spurious = 1'b0;
         end else if (!mon_busy) begin
            if (out_bit === 1'b1) begin
               spurious = 1'b0;
               idle_run++;
            end else if (!spurious) begin
               if (exp_q.size() == 0) begin
                  compared++;
                  mismatched++;
                  spurious = 1'b1;
                  $display("FAIL unexpected_start: out_bit=%b with no frame queued, required 1", out_bit);
               end else begin
                  cur      = exp_q.pop_front();
                  mon_busy = 1'b1;
                  mon_idx  = 1;
                  mon_err  = 0;
                  gaps_q.push_back(idle_run);
                  idle_run = 0;
               end
            end
         end else begin
            if (out_bit !== cur.bits[mon_idx / cur.period]) mon_err++;
            mon_idx++;
            if (mon_idx == cur.nbits * cur.period) begin
               compared++;
               frame_no++;
               mon_busy = 1'b0;
               if (mon_err != 0) begin
                  mismatched++;
                  $display("FAIL frame %0d: word 0x%03h had %0d wrong line cycles, required 0",
                           frame_no, cur.word, mon_err);
               end else begin
                  $display("frame %0d: word 0x%03h, %0d bits x %0d cycles ok",
                           frame_no, cur.word, cur.nbits, cur.period);
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int bad;
      int nw;
      logic [8:0] w0;
      logic [8:0] w1;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_out_bit", 32'(out_bit), 1);
      check("reset_busy", 32'(busy), 0);
      check("reset_ready", 32'(data_in_ready), 1);
      check("reset_level", 32'(fifo_level), 0);
      @(posedge clk);
      #1;

      // 0xA5, 8 bits, 4-cycle bits: start latency and 40-cycle frame.
      set_cfg(3, 3, 0, 1'b0);
      tx_enable = 1'b1;
      write_word(9'h0A5, 1'b1);
      @(negedge clk);
      check("line_idle_on_write_cycle", 32'(out_bit), 1);
      @(negedge clk);
      check("start_next_cycle", 32'(out_bit), 0);
      check("busy_at_start", 32'(busy), 1);
      repeat (39) @(negedge clk);
      check("busy_in_last_stop_cycle", 32'(busy), 1);
      @(negedge clk);
      check("busy_low_after_40", 32'(busy), 0);
      @(posedge clk);
      #1;
      drain(200);

      // Parity frames (plain frames when the parity build option is off).
      set_cfg(0, 2, 1, 1'b0);
      write_word(9'h003, 1'b1);
      drain(100);
      set_cfg(0, 2, 2, 1'b0);
      write_word(9'h003, 1'b1);
      drain(100);
      set_cfg(1, 4, 1, 1'b0);
      write_word(9'h1FF, 1'b1);
      drain(100);

      // Two stop bits at one cycle per bit, second write lands on the pop edge.
      set_cfg(0, 0, 0, 1'b1);
      gaps_q.delete();
      write_word(9'h015, 1'b1);
      write_word(9'h00A, 1'b1);
      @(negedge clk);
      check("level_write_with_pop", 32'(fifo_level), 1);
      @(posedge clk);
      #1;
      drain(100);
      g = (gaps_q.size() >= 2) ? gaps_q[1] : -1;
      check("two_stop_gap", 32'(g), 0);

      // Fill while disabled: fifth write dropped, then four back-to-back frames.
      set_cfg(1, 3, 0, 1'b0);
      tx_enable = 1'b0;
      for (int i = 0; i < 5; i++) write_word(9'(8'h30 + i), i < FifoDepth);
      @(negedge clk);
      check("full_ready_low", 32'(data_in_ready), 0);
      check("full_level", 32'(fifo_level), FifoDepth);
      check("disabled_not_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      gaps_q.delete();
      tx_enable = 1'b1;
      drain(400);
      g = (gaps_q.size() == 4) ? gaps_q[1] + gaps_q[2] + gaps_q[3] : -1;
      check("back_to_back_gaps", 32'(g), 0);

      // Divider change mid-frame applies to the next frame only.
      set_cfg(3, 3, 0, 1'b0);
      write_word(9'h0C3, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      clk_div = 16'd7;
      write_word(9'h05A, 1'b1);
      drain(300);

      // Reset in the middle of the data bits with two words still queued.
      set_cfg(1, 3, 0, 1'b0);
      write_word(9'h0F0, 1'b1);
      write_word(9'h00F, 1'b1);
      write_word(9'h0AA, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("busy_before_rst", 32'(busy), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_bit", 32'(out_bit), 1);
      check("rst_level", 32'(fifo_level), 0);
      check("rst_busy", 32'(busy), 0);
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (out_bit !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("quiet_after_rst", 32'(bad), 0);
      @(posedge clk);
      #1;

      // Random bursts, sometimes pausing tx_enable while a frame is on the line.
      for (int b = 0; b < 10; b++) begin
         set_cfg($urandom_range(0, 4), $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         tx_enable = 1'b1;
         nw = $urandom_range(1, 4);
         for (int k = 0; k < nw; k++) begin
            w0 = 9'($urandom_range(0, 511));
            write_word(w0, 1'b1);
         end
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(2, 20)) @(posedge clk);
            #1 tx_enable = 1'b0;
            repeat (90) @(posedge clk);
            #1 tx_enable = 1'b1;
         end
         drain(1500);
      end

      // Final two-word stress with maximum data length.
      set_cfg(2, 7, 2, 1'b1);
      w0 = 9'($urandom_range(0, 511));
      w1 = 9'($urandom_range(0, 511));
      write_word(w0, 1'b1);
      write_word(w1, 1'b1);
      drain(500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter ClkDivWidth, default 16: width of the runtime bit-period divider.
REQ-002 Parameter FifoDepth, default 4, power of two >= 2: transmit FIFO entries.
REQ-003 Parameter MaxDataBits, default 9: FIFO entry width and data_in width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clk_div  input  ClkDivWidth  bit period = clk_div+1 clk cycles.
REQ-007 data_bits  input  3  frame data length minus 5 (0..4 → 5..9 bits); codes 5..7 treated as 9.
REQ-008 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 two_stop  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 tx_enable  input  1  permits starting new frames.
REQ-011 data_in  input  MaxDataBits  word to send, LSB first.
REQ-012 data_in_valid  input  1  write request.
REQ-013 data_in_ready  output  1  high when FIFO not full.
REQ-014 out_bit  output  1  serial line, idle high.
REQ-015 busy  output  1  high while FSM is not IDLE.
REQ-016 fifo_level  output  $clog2(FifoDepth)+1  current FIFO occupancy.

Function
REQ-017 A word SHALL be written when data_in_valid && data_in_ready on a rising edge; writes while full are dropped.
REQ-018 data_in_ready SHALL depend only on registered occupancy; no same-cycle pass-through when full.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE→START when FIFO non-empty and tx_enable; FIFO pops on that edge; clk_div, data_bits, parity_mode, two_stop latched on that edge and held for the frame.
REQ-021 out_bit SHALL be registered: 0 in START, data bit i in DATA, parity in PARITY, 1 in STOP and IDLE.
REQ-022 Each bit SHALL last exactly latched clk_div+1 cycles; clk_div=0 gives one cycle per bit.
REQ-023 START→DATA after one bit; DATA→PARITY after last data bit when parity enabled, else →STOP; PARITY→STOP after one bit.
REQ-024 STOP lasts 1 or 2 bit periods; then →START directly if FIFO non-empty and tx_enable (back-to-back frames, no idle gap), else →IDLE.
REQ-025 Parity SHALL be XOR of the data_bits+5 transmitted bits (even), inverted for odd; unused high data bits ignored.
REQ-026 Deasserting tx_enable mid-frame SHALL NOT abort the frame; only the next start is blocked.
REQ-027 Start bit SHALL appear on out_bit the cycle after the write edge when FIFO was empty and FSM IDLE.
REQ-028 Simultaneous write and pop SHALL leave fifo_level unchanged and accept the write.
REQ-029 Config inputs changed mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-030 On rst: FSM IDLE, FIFO empty, fifo_level 0, out_bit 1, busy 0, data_in_ready 1, divider and bit counters 0.
REQ-031 rst mid-frame SHALL force out_bit high on the next edge and discard all buffered words.

Configuration
REQ-032 Macro UART_TX_PARITY_EN: when defined, parity_mode acts per REQ-008/REQ-025.
REQ-033 Without UART_TX_PARITY_EN, parity_mode SHALL be ignored, PARITY state and parity logic absent, frames never carry a parity bit.

Structure
REQ-034 Package uart_pkg SHALL hold parity_mode_t enum, tx_state_t enum, and data_bits code constants.
REQ-035 The FIFO SHALL be a sub-module sync_fifo (Width, Depth parameters, full/empty/level outputs).

Verification
REQ-036 clk_div=3, data_bits=3 (8b), parity none, one stop, write 0xA5 → out_bit 0,1,0,1,0,0,1,0,1,1 each 4 cycles, busy 0 after 40 cycles.
REQ-037 UART_TX_PARITY_EN, 7 bits even, write 0x03 → parity bit 0; odd → 1; 9 bits even, write 0x1FF → parity 1.
REQ-038 Write 5 words with FifoDepth=4 while tx_enable=0 → 4 accepted, data_in_ready 0, fifo_level 4; raise tx_enable → 4 back-to-back frames, no idle cycles between stop and start.
REQ-039 two_stop=1, clk_div=0 → stop high for exactly 2 cycles before next start bit.
REQ-040 Assert rst mid-DATA of frame 1 with 2 queued → out_bit 1 next edge, fifo_level 0, no further frames.
REQ-041 Change clk_div 3→7 mid-frame → current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
